// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - load port and serial output bundle of seq_pattern_tx
interface seq_pattern_tx_if #(
  parameter int PAT_W = 3,
  parameter int REP_W = 4
);
  logic             pat_valid;
  logic             pat_ready;
  logic [PAT_W-1:0] pat_data;
  logic [REP_W-1:0] pat_reps;
  logic             tx_bit;
  logic             tx_valid;
  logic             done;

  modport master (
    output pat_valid, pat_data, pat_reps,
    input  pat_ready, tx_bit, tx_valid, done
  );

  modport slave (
    input  pat_valid, pat_data, pat_reps,
    output pat_ready, tx_bit, tx_valid, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial bit-pattern transmitter, MSB first, with repeats and gaps
module seq_pattern_tx #(
  parameter int PAT_W      = 3,
  parameter int REP_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic           clk,
  input  logic           areset_n,
  seq_pattern_tx_if.slave bus
);

  localparam int CW       = $clog2(PAT_W) + 1;
  localparam int GW       = $clog2(GAP_CYCLES) + 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] sh;        // sh[PAT_W-1] is the bit currently on tx_bit
  logic [PAT_W-1:0] pat_q;     // latched copy used to reload each repetition
  logic [CW-1:0]    bit_cnt;   // index of the bit currently on tx_bit
  logic [REP_W-1:0] reps_left;
  logic [GW-1:0]    gap_cnt;
  logic [PAT_W-1:0] sh_next;

  // Rotate rather than shift so the expression stays valid for PAT_W=1;
  // the wrapped-in bit is never transmitted because a reload follows.
  assign sh_next = (sh << 1) | (sh >> (PAT_W - 1));

  // Ready is a pure decode of the state register
  assign bus.pat_ready = (state == IDLE);

  // Transmit sequencer: owns state, counters and all registered outputs
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state        <= IDLE;
      sh           <= '0;
      pat_q        <= '0;
      bit_cnt      <= '0;
      reps_left    <= '0;
      gap_cnt      <= '0;
      bus.tx_bit   <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.tx_bit   <= 1'b0;
          bus.tx_valid <= 1'b0;
          if (bus.pat_valid) begin
            sh           <= bus.pat_data;
            pat_q        <= bus.pat_data;
            reps_left    <= (bus.pat_reps == '0) ? REP_W'(1) : bus.pat_reps;
            bit_cnt      <= '0;
            bus.tx_bit   <= bus.pat_data[PAT_W-1];
            bus.tx_valid <= 1'b1;
            state        <= SHIFT;
          end
        end

        SHIFT: begin
          if (bit_cnt == CW'(PAT_W - 1)) begin
            // Last bit of this repetition is on the line now
            reps_left <= reps_left - REP_W'(1);
            bit_cnt   <= '0;
            if (reps_left == REP_W'(1)) begin
              bus.tx_bit   <= 1'b0;
              bus.tx_valid <= 1'b0;
              bus.done     <= 1'b1;
              state        <= IDLE;
            end else if (GAP_CYCLES > 0) begin
              bus.tx_bit   <= 1'b0;
              bus.tx_valid <= 1'b0;
              gap_cnt      <= '0;
              state        <= GAP;
            end else begin
              sh           <= pat_q;
              bus.tx_bit   <= pat_q[PAT_W-1];
              bus.tx_valid <= 1'b1;
            end
          end else begin
            sh           <= sh_next;
            bus.tx_bit   <= sh_next[PAT_W-1];
            bus.tx_valid <= 1'b1;
            bit_cnt      <= bit_cnt + CW'(1);
          end
        end

        GAP: begin
          bus.tx_bit   <= 1'b0;
          bus.tx_valid <= 1'b0;
          if (gap_cnt == GW'(GAP_LAST)) begin
            sh           <= pat_q;
            bit_cnt      <= '0;
            bus.tx_bit   <= pat_q[PAT_W-1];
            bus.tx_valid <= 1'b1;
            state        <= SHIFT;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: begin
          bus.tx_bit   <= 1'b0;
          bus.tx_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx (gap of 1 and gap of 0)
module tb_seq_pattern_tx;

  logic clk;
  logic areset_n;
  int   checks;
  int   failures;
  bit   sel;   // 0: DUT with one gap cycle, 1: DUT with no gap

  logic       pat_valid;
  logic [2:0] pat_data;
  logic [3:0] pat_reps;

  logic obs_valid, obs_bit, obs_ready, obs_done;

  seq_pattern_tx_if #(.PAT_W(3), .REP_W(4)) b0 ();
  seq_pattern_tx_if #(.PAT_W(3), .REP_W(4)) b1 ();

  seq_pattern_tx #(.PAT_W(3), .REP_W(4), .GAP_CYCLES(1)) dut_gap1 (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (b0)
  );

  seq_pattern_tx #(.PAT_W(3), .REP_W(4), .GAP_CYCLES(0)) dut_gap0 (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (b1)
  );

  assign b0.pat_valid = pat_valid;
  assign b0.pat_data  = pat_data;
  assign b0.pat_reps  = pat_reps;
  assign b1.pat_valid = pat_valid;
  assign b1.pat_data  = pat_data;
  assign b1.pat_reps  = pat_reps;

  assign obs_valid = sel ? b1.tx_valid  : b0.tx_valid;
  assign obs_bit   = sel ? b1.tx_bit    : b0.tx_bit;
  assign obs_ready = sel ? b1.pat_ready : b0.pat_ready;
  assign obs_done  = sel ? b1.done      : b0.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer against the reference stream: the stream is the pattern
  // MSB-first repeated max(reps,1) times with `gap` idle cycles between copies.
  task automatic xfer(input logic [2:0] d, input logic [3:0] r, input bit hold, input string tag);
    int   n;
    int   g;
    bit   ok;
    bit   ev[$];
    bit   eb[$];
    g = sel ? 0 : 1;
    n = (r == 0) ? 1 : int'(r);
    for (int k = 0; k < n; k++) begin
      for (int i = 2; i >= 0; i--) begin
        ev.push_back(1'b1);
        eb.push_back(d[i]);
      end
      if (k < n - 1)
        for (int j = 0; j < g; j++) begin
          ev.push_back(1'b0);
          eb.push_back(1'b0);
        end
    end
    ok = 1'b0;
    for (int w = 0; w < 200 && !ok; w++) begin
      if (obs_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_ready_wait"}, 32'(ok), 32'd1);
    pat_valid = 1'b1;
    pat_data  = d;
    pat_reps  = r;
    @(posedge clk);
    #1;
    if (hold) begin
      pat_data = 3'($urandom);
      pat_reps = 4'($urandom);
    end else begin
      pat_valid = 1'b0;
    end
    for (int i = 0; i < ev.size(); i++) begin
      @(negedge clk);
      check({tag, "_valid"}, 32'(obs_valid), 32'(ev[i]));
      check({tag, "_bit"},   32'(obs_bit),   32'(eb[i]));
      check({tag, "_busy"},  32'(obs_ready), 32'd0);
      check({tag, "_nodone"}, 32'(obs_done), 32'd0);
      if (hold) begin
        pat_data = 3'($urandom);
        pat_reps = 4'($urandom);
      end
    end
    @(negedge clk);
    check({tag, "_done"},       32'(obs_done),  32'd1);
    check({tag, "_done_ready"}, 32'(obs_ready), 32'd1);
    check({tag, "_done_valid"}, 32'(obs_valid), 32'd0);
    check({tag, "_done_bit"},   32'(obs_bit),   32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    sel       = 1'b0;
    pat_valid = 1'b0;
    pat_data  = '0;
    pat_reps  = '0;
    areset_n  = 1'b0;
    #1;
    // Reset values while reset is asserted, before any clock edge
    check("rst_valid0", 32'(b0.tx_valid),  32'd0);
    check("rst_bit0",   32'(b0.tx_bit),    32'd0);
    check("rst_done0",  32'(b0.done),      32'd0);
    check("rst_ready0", 32'(b0.pat_ready), 32'd1);
    check("rst_valid1", 32'(b1.tx_valid),  32'd0);
    check("rst_ready1", 32'(b1.pat_ready), 32'd1);
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);

    // Directed: single 101, two repetitions with gap, reps=0 as one
    xfer(3'b101, 4'd1, 1'b0, "t1_101x1");
    xfer(3'b101, 4'd2, 1'b0, "t2_101x2");
    xfer(3'b110, 4'd0, 1'b0, "t3_110x0");

    // pat_valid held high with changing data; back-to-back accepts at done
    xfer(3'b011, 4'd2, 1'b1, "t4_hold_a");
    xfer(3'b100, 4'd1, 1'b1, "t4_hold_b");
    xfer(3'b111, 4'd3, 1'b1, "t4_hold_c");
    pat_valid = 1'b0;

    // Reset during the second bit of a reps=3 transfer
    @(negedge clk);
    check("t5_ready_pre", 32'(obs_ready), 32'd1);
    pat_valid = 1'b1;
    pat_data  = 3'b110;
    pat_reps  = 4'd3;
    @(posedge clk);
    #1;
    pat_valid = 1'b0;
    @(negedge clk);
    check("t5_bit1", 32'({obs_valid, obs_bit}), 32'b11);
    @(negedge clk);
    check("t5_bit2", 32'({obs_valid, obs_bit}), 32'b11);
    #2;
    areset_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(obs_valid), 32'd0);
    check("t5_rst_bit",   32'(obs_bit),   32'd0);
    check("t5_rst_ready", 32'(obs_ready), 32'd1);
    check("t5_rst_done",  32'(obs_done),  32'd0);
    @(negedge clk);
    areset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t5_no_done",  32'(obs_done),  32'd0);
      check("t5_no_valid", 32'(obs_valid), 32'd0);
    end
    xfer(3'b101, 4'd1, 1'b0, "t5_fresh");

    // No-gap instance: contiguous repetitions
    sel = 1'b1;
    @(negedge clk);
    xfer(3'b011, 4'd2, 1'b0, "t6_011x2");
    xfer(3'b101, 4'd0, 1'b0, "t6_101x0");

    // Randomized transfers on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      pat_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 12; k++)
        xfer(3'($urandom_range(0, 7)), 4'($urandom_range(0, 5)),
             1'($urandom_range(0, 1)), "rand");
      pat_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
